// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: load kinds, access FSM states, HI/LO select bits.
package mem_stage_pkg;

    localparam int unsigned LD_W = 3;

    localparam logic [LD_W-1:0] LD_NONE = 3'd0;
    localparam logic [LD_W-1:0] LD_LB   = 3'd1;
    localparam logic [LD_W-1:0] LD_LBU  = 3'd2;
    localparam logic [LD_W-1:0] LD_LH   = 3'd3;
    localparam logic [LD_W-1:0] LD_LHU  = 3'd4;
    localparam logic [LD_W-1:0] LD_LW   = 3'd5;
    localparam logic [LD_W-1:0] LD_LWL  = 3'd6;
    localparam logic [LD_W-1:0] LD_LWR  = 3'd7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2
    } mem_state_e;

    // Bit positions inside the MFHL/MTHL select fields
    localparam int unsigned HL_HI = 1;
    localparam int unsigned HL_LO = 0;

endpackage

// File: rtl/load_align.sv
// Combinational load-data alignment: byte/half extension and the lwl/lwr register merge.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [LD_W-1:0] ld_type,
    input  logic [1:0]      offset,
    input  logic [31:0]     rdata,
    input  logic [31:0]     rt,
    output logic [31:0]     result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        result   = rdata;
        case (ld_type)
            LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            LD_LBU:  result = {24'd0, byte_sel};
            LD_LH:   result = {{16{half_sel[15]}}, half_sel};
            LD_LHU:  result = {16'd0, half_sel};
            LD_LWL: begin
                case (offset)
                    2'd0:    result = {rdata[7:0],  rt[23:0]};
                    2'd1:    result = {rdata[15:0], rt[15:0]};
                    2'd2:    result = {rdata[23:0], rt[7:0]};
                    default: result = rdata;
                endcase
            end
            LD_LWR: begin
                case (offset)
                    2'd0:    result = rdata;
                    2'd1:    result = {rt[31:24], rdata[31:8]};
                    2'd2:    result = {rt[31:16], rdata[31:16]};
                    default: result = {rt[31:8],  rdata[31:24]};
                endcase
            end
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// MIPS MEM stage: data-SRAM handshake FSM, load alignment, HI/LO registers and MEM->WB registers.
// Optional stall-cycle counter built when MEM_STALL_CNT_EN is defined.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] HILO_RST_VAL = 32'd0,
    parameter int unsigned STALL_CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_EXE_MEM,
    input  logic                   flush,
    input  logic                   MemEn_EXE_MEM,
    input  logic [3:0]             MemWrite_EXE_MEM,
    input  logic [31:0]            ALUResult_EXE_MEM,
    input  logic [31:0]            MemWdata_EXE_MEM,
    input  logic [31:0]            RegRdata1_EXE_MEM,
    input  logic [31:0]            RegRdata2_EXE_MEM,
    input  logic [LD_W-1:0]        LdType_EXE_MEM,
    input  logic [1:0]             MFHL_EXE_MEM,
    input  logic [1:0]             MTHL_EXE_MEM,
    input  logic [3:0]             RegWrite_EXE_MEM,
    input  logic [4:0]             RegWaddr_EXE_MEM,
    output logic                   data_req,
    output logic [3:0]             data_wstrb,
    output logic [31:0]            data_addr,
    output logic [31:0]            data_wdata,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    input  logic [31:0]            data_rdata,
    output logic                   stall_MEM,
    output logic [31:0]            Bypass_MEM,
    output logic                   valid_MEM_WB,
    output logic [3:0]             RegWrite_MEM_WB,
    output logic [4:0]             RegWaddr_MEM_WB,
    output logic [31:0]            RegWdata_MEM_WB,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    mem_state_e  state, state_nxt;
    logic        kill, kill_nxt;
    logic        mem_op, req_c, stall_c, commit;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [31:0] hi, lo, load_data, wb_data;

    assign mem_op = valid_EXE_MEM & MemEn_EXE_MEM & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    // Once issued, a request runs to its response; a flush only marks it for discard
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        req_c     = 1'b0;
        case (state)
            IDLE: begin
                req_c    = mem_op;
                kill_nxt = 1'b0;
                if (mem_op) begin
                    state_nxt = data_addr_ok ? WAIT_DATA : WAIT_ADDR;
                end
            end
            WAIT_ADDR: begin
                req_c    = 1'b1;
                kill_nxt = kill | flush;
                if (data_addr_ok) begin
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                kill_nxt = kill | flush;
                if (data_data_ok) begin
                    state_nxt = IDLE;
                    kill_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                kill_nxt  = 1'b0;
            end
        endcase
    end

    // Request payload captured at issue so it stays stable while waiting for addr_ok
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr  <= 32'd0;
            req_wstrb <= 4'd0;
            req_wdata <= 32'd0;
        end else if (state == IDLE && mem_op) begin
            req_addr  <= {ALUResult_EXE_MEM[31:2], 2'b00};
            req_wstrb <= MemWrite_EXE_MEM;
            req_wdata <= MemWdata_EXE_MEM;
        end
    end

    assign data_req   = req_c & ~rst;
    assign data_addr  = rst ? 32'd0 :
                        (state == IDLE) ? {ALUResult_EXE_MEM[31:2], 2'b00} : req_addr;
    assign data_wstrb = rst ? 4'd0 : (state == IDLE) ? MemWrite_EXE_MEM : req_wstrb;
    assign data_wdata = rst ? 32'd0 : (state == IDLE) ? MemWdata_EXE_MEM : req_wdata;

    // A discarded access still blocks the slot until its response drains
    assign stall_c   = (mem_op & ~(state == WAIT_DATA & data_data_ok & ~kill)) |
                       (state != IDLE & kill);
    assign stall_MEM = stall_c & ~rst;
    assign commit    = valid_EXE_MEM & ~flush & ~stall_c;

    load_align u_load_align (
        .ld_type (LdType_EXE_MEM),
        .offset  (ALUResult_EXE_MEM[1:0]),
        .rdata   (data_rdata),
        .rt      (RegRdata2_EXE_MEM),
        .result  (load_data)
    );

    always_comb begin
        wb_data = ALUResult_EXE_MEM;
        if (LdType_EXE_MEM != LD_NONE) begin
            wb_data = load_data;
        end else if (MFHL_EXE_MEM != 2'b00) begin
            wb_data = MFHL_EXE_MEM[HL_HI] ? hi : lo;
        end
    end

    assign Bypass_MEM = rst ? 32'd0 : wb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= HILO_RST_VAL;
            lo <= HILO_RST_VAL;
        end else if (commit) begin
            if (MTHL_EXE_MEM[HL_HI]) hi <= RegRdata1_EXE_MEM;
            if (MTHL_EXE_MEM[HL_LO]) lo <= RegRdata1_EXE_MEM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_MEM_WB    <= 1'b0;
            RegWrite_MEM_WB <= 4'd0;
            RegWaddr_MEM_WB <= 5'd0;
            RegWdata_MEM_WB <= 32'd0;
        end else if (commit) begin
            valid_MEM_WB    <= 1'b1;
            RegWrite_MEM_WB <= RegWrite_EXE_MEM;
            RegWaddr_MEM_WB <= RegWaddr_EXE_MEM;
            RegWdata_MEM_WB <= wb_data;
        end else begin
            valid_MEM_WB    <= 1'b0;
            RegWrite_MEM_WB <= 4'd0;
        end
    end

`ifdef MEM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall_MEM) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage against a transaction-level model of the MEM stage.
module tb_memory_stage;
    import mem_stage_pkg::*;

    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst;
    logic valid_EXE_MEM, flush, MemEn_EXE_MEM;
    logic [3:0]  MemWrite_EXE_MEM, RegWrite_EXE_MEM;
    logic [31:0] ALUResult_EXE_MEM, MemWdata_EXE_MEM, RegRdata1_EXE_MEM, RegRdata2_EXE_MEM;
    logic [2:0]  LdType_EXE_MEM;
    logic [1:0]  MFHL_EXE_MEM, MTHL_EXE_MEM;
    logic [4:0]  RegWaddr_EXE_MEM;
    logic        data_req, data_addr_ok, data_data_ok;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        stall_MEM, valid_MEM_WB;
    logic [31:0] Bypass_MEM, RegWdata_MEM_WB;
    logic [3:0]  RegWrite_MEM_WB;
    logic [4:0]  RegWaddr_MEM_WB;
    logic [CW-1:0] stall_cnt;

    memory_stage #(.HILO_RST_VAL(32'd0), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .valid_EXE_MEM(valid_EXE_MEM), .flush(flush),
        .MemEn_EXE_MEM(MemEn_EXE_MEM), .MemWrite_EXE_MEM(MemWrite_EXE_MEM),
        .ALUResult_EXE_MEM(ALUResult_EXE_MEM), .MemWdata_EXE_MEM(MemWdata_EXE_MEM),
        .RegRdata1_EXE_MEM(RegRdata1_EXE_MEM), .RegRdata2_EXE_MEM(RegRdata2_EXE_MEM),
        .LdType_EXE_MEM(LdType_EXE_MEM), .MFHL_EXE_MEM(MFHL_EXE_MEM), .MTHL_EXE_MEM(MTHL_EXE_MEM),
        .RegWrite_EXE_MEM(RegWrite_EXE_MEM), .RegWaddr_EXE_MEM(RegWaddr_EXE_MEM),
        .data_req(data_req), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stall_MEM(stall_MEM), .Bypass_MEM(Bypass_MEM), .valid_MEM_WB(valid_MEM_WB),
        .RegWrite_MEM_WB(RegWrite_MEM_WB), .RegWaddr_MEM_WB(RegWaddr_MEM_WB),
        .RegWdata_MEM_WB(RegWdata_MEM_WB), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid, memen;
        logic [3:0]  mw, rw;
        logic [31:0] alu, wd, rs, rt, rd;
        logic [2:0]  ld;
        logic [1:0]  mf, mt;
        logic [4:0]  wa;
        int          a_dly, d_dly, flush_at;
        logic        lit_en;
        logic [31:0] lit;
        int          lit_stall;
    } ins_t;

    int n_checks = 0;
    int n_fail   = 0;

    ins_t dq[$];
    ins_t cur;
    int   age;
    bit   rand_mode = 1'b0;
    bit   chk_en    = 1'b0;

    // Transaction model: 0 none, 1 waiting for acceptance, 2 waiting for response
    int          t_st, t_cnt, t_a, t_d;
    logic        t_kill;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wstrb;
    logic [31:0] m_hi, m_lo;
    logic [CW-1:0] m_cnt;

    logic        e_req, e_stall, e_commit, e_first;
    logic [31:0] e_addr, e_wdata, e_byp;
    logic [3:0]  e_wstrb;
    int          e_lit_stall;
    logic [CW-1:0] e_cnt;
    logic        w_v, w_lit_en, nx_v, nx_lit_en;
    logic [3:0]  w_rw, nx_rw;
    logic [4:0]  w_wa, nx_wa;
    logic [31:0] w_wd, w_lit, nx_wd, nx_lit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Load result from the ISA definition: shift/mask arithmetic on the response word
    function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [1:0] b,
                                             input logic [31:0] d, input logic [31:0] rt);
        int          sh;
        logic [31:0] bv, hv;
        bv = (d >> (8 * int'(b))) & 32'hFF;
        hv = (d >> (16 * int'(b[1]))) & 32'hFFFF;
        case (ld)
            LD_LB:   return bv[7] ? (bv | 32'hFFFF_FF00) : bv;
            LD_LBU:  return bv;
            LD_LH:   return hv[15] ? (hv | 32'hFFFF_0000) : hv;
            LD_LHU:  return hv;
            LD_LW:   return d;
            LD_LWL: begin
                sh = 8 * (3 - int'(b));
                return (d << sh) | (rt & ((32'h1 << sh) - 32'h1));
            end
            LD_LWR: begin
                sh = 8 * int'(b);
                return (d >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            end
            default: return 32'h0;
        endcase
    endfunction

    function automatic ins_t blank();
        ins_t i;
        i.valid = 1'b1; i.memen = 1'b0; i.mw = 4'd0; i.rw = 4'd0;
        i.alu = 32'd0; i.wd = 32'd0; i.rs = 32'd0; i.rt = 32'd0; i.rd = 32'd0;
        i.ld = LD_NONE; i.mf = 2'd0; i.mt = 2'd0; i.wa = 5'd0;
        i.a_dly = 0; i.d_dly = 1; i.flush_at = 99;
        i.lit_en = 1'b0; i.lit = 32'd0; i.lit_stall = -1;
        return i;
    endfunction

    function automatic ins_t gen_rand();
        ins_t i;
        int   k;
        i = blank();
        i.valid = ($urandom % 10) != 0;
        i.alu = $urandom; i.wd = $urandom; i.rs = $urandom; i.rt = $urandom; i.rd = $urandom;
        i.wa = 5'($urandom);
        i.a_dly = int'($urandom % 4);
        i.d_dly = 1 + int'($urandom % 3);
        i.flush_at = (($urandom % 10) == 0) ? int'($urandom % 5) : 99;
        k = int'($urandom % 5);
        case (k)
            0: i.rw = 4'($urandom);
            1: i.mt = 2'(1 + $urandom % 3);
            2: begin i.mf = 2'(1 + $urandom % 3); i.rw = 4'hF; end
            3: begin i.memen = 1'b1; i.ld = 3'(1 + $urandom % 7); i.rw = 4'hF; end
            default: begin i.memen = 1'b1; i.mw = 4'(1 + $urandom % 15); end
        endcase
        return i;
    endfunction

    function automatic ins_t next_ins();
        ins_t i;
        if (dq.size() != 0) i = dq.pop_front();
        else if (rand_mode) i = gen_rand();
        else begin i = blank(); i.valid = 1'b0; end
        return i;
    endfunction

    task automatic drive_idle();
        valid_EXE_MEM = 1'b0; flush = 1'b0; MemEn_EXE_MEM = 1'b0; MemWrite_EXE_MEM = 4'd0;
        ALUResult_EXE_MEM = 32'd0; MemWdata_EXE_MEM = 32'd0; RegRdata1_EXE_MEM = 32'd0;
        RegRdata2_EXE_MEM = 32'd0; LdType_EXE_MEM = 3'd0; MFHL_EXE_MEM = 2'd0; MTHL_EXE_MEM = 2'd0;
        RegWrite_EXE_MEM = 4'd0; RegWaddr_EXE_MEM = 5'd0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    endtask

    task automatic model_reset();
        cur = blank(); cur.valid = 1'b0; age = 0;
        t_st = 0; t_cnt = 0; t_a = 0; t_d = 0; t_kill = 1'b0;
        t_addr = 32'd0; t_wdata = 32'd0; t_wstrb = 4'd0;
        m_hi = 32'd0; m_lo = 32'd0; m_cnt = '0;
        nx_v = 1'b0; nx_rw = 4'd0; nx_wa = 5'd0; nx_wd = 32'd0; nx_lit_en = 1'b0; nx_lit = 32'd0;
    endtask

    // One clock cycle: drive inputs, predict this cycle and the next edge, advance the model
    task automatic step();
        logic        fl, mop, aok, dok, blocked, com;
        logic [31:0] rdv, wbd;
        w_v = nx_v; w_rw = nx_rw; w_wa = nx_wa; w_wd = nx_wd; w_lit_en = nx_lit_en; w_lit = nx_lit;
        e_cnt = m_cnt;

        fl  = cur.valid && (age == cur.flush_at);
        mop = cur.valid && cur.memen && !fl;
        dok = ($urandom % 4) == 0;
        if (t_st == 0)      aok = mop ? (cur.a_dly == 0) : 1'($urandom % 2);
        else if (t_st == 1) aok = (t_cnt >= t_a);
        else begin          aok = 1'($urandom % 2); dok = (t_cnt >= t_d); end
        rdv = (t_st == 2 && !t_kill) ? cur.rd : $urandom;

        valid_EXE_MEM = cur.valid; flush = fl; MemEn_EXE_MEM = cur.memen;
        MemWrite_EXE_MEM = cur.mw; ALUResult_EXE_MEM = cur.alu; MemWdata_EXE_MEM = cur.wd;
        RegRdata1_EXE_MEM = cur.rs; RegRdata2_EXE_MEM = cur.rt; LdType_EXE_MEM = cur.ld;
        MFHL_EXE_MEM = cur.mf; MTHL_EXE_MEM = cur.mt; RegWrite_EXE_MEM = cur.rw;
        RegWaddr_EXE_MEM = cur.wa; data_addr_ok = aok; data_data_ok = dok; data_rdata = rdv;

        e_req = (t_st == 0) ? mop : (t_st == 1);
        if (t_st == 0) begin
            e_addr = {cur.alu[31:2], 2'b00}; e_wstrb = cur.mw; e_wdata = cur.wd;
        end else begin
            e_addr = t_addr; e_wstrb = t_wstrb; e_wdata = t_wdata;
        end
        blocked = (t_st != 0) && t_kill;
        com = cur.valid && !fl && !blocked && (cur.memen ? (t_st == 2 && dok) : 1'b1);
        e_stall = blocked || (mop && !com);
        wbd = (cur.ld != LD_NONE) ? ref_load(cur.ld, cur.alu[1:0], rdv, cur.rt) :
              (cur.mf != 2'd0)    ? (cur.mf[1] ? m_hi : m_lo) : cur.alu;
        e_commit = com; e_byp = wbd; e_first = (age == 0);
        e_lit_stall = com ? cur.lit_stall : -1;

        nx_v = com; nx_rw = com ? cur.rw : 4'd0; nx_lit_en = 1'b0;
        if (com) begin
            nx_wa = cur.wa; nx_wd = wbd; nx_lit_en = cur.lit_en; nx_lit = cur.lit;
            if (cur.mt[1]) m_hi = cur.rs;
            if (cur.mt[0]) m_lo = cur.rs;
        end
`ifdef MEM_STALL_CNT_EN
        m_cnt = m_cnt + CW'(e_stall);
`endif
        case (t_st)
            0: if (mop) begin
                t_addr = {cur.alu[31:2], 2'b00}; t_wstrb = cur.mw; t_wdata = cur.wd;
                t_kill = 1'b0; t_a = cur.a_dly; t_d = cur.d_dly; t_cnt = 1;
                t_st = aok ? 2 : 1;
            end
            1: begin
                t_kill = t_kill | fl;
                if (aok) begin t_st = 2; t_cnt = 1; end else t_cnt++;
            end
            default: begin
                t_kill = t_kill | fl;
                if (dok) begin t_st = 0; t_kill = 1'b0; end else t_cnt++;
            end
        endcase
        if (com || fl || !cur.valid) begin cur = next_ins(); age = 0; end
        else age++;

        @(posedge clk); #1;
    endtask

    int run = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("data_req", 32'(data_req), 32'(e_req));
            if (e_req) begin
                check("data_addr", data_addr, e_addr);
                check("data_wstrb", 32'(data_wstrb), 32'(e_wstrb));
                check("data_wdata", data_wdata, e_wdata);
            end
            check("stall_MEM", 32'(stall_MEM), 32'(e_stall));
            if (e_commit) check("Bypass_MEM", Bypass_MEM, e_byp);
            check("valid_MEM_WB", 32'(valid_MEM_WB), 32'(w_v));
            check("RegWrite_MEM_WB", 32'(RegWrite_MEM_WB), 32'(w_rw));
            if (w_v) begin
                check("RegWaddr_MEM_WB", 32'(RegWaddr_MEM_WB), 32'(w_wa));
                check("RegWdata_MEM_WB", RegWdata_MEM_WB, w_wd);
                if (w_lit_en) check("RegWdata_literal", RegWdata_MEM_WB, w_lit);
            end
            check("stall_cnt", 32'(stall_cnt), 32'(e_cnt));
            if (e_first) run = 0;
            if (e_commit && e_lit_stall >= 0) check("stall_cycles", 32'(run), 32'(e_lit_stall));
            run += int'(stall_MEM);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data_req"}, 32'(data_req), 32'd0);
        check({tag, "_stall_MEM"}, 32'(stall_MEM), 32'd0);
        check({tag, "_valid_MEM_WB"}, 32'(valid_MEM_WB), 32'd0);
        check({tag, "_RegWrite_MEM_WB"}, 32'(RegWrite_MEM_WB), 32'd0);
        check({tag, "_RegWdata_MEM_WB"}, RegWdata_MEM_WB, 32'd0);
        check({tag, "_Bypass_MEM"}, Bypass_MEM, 32'd0);
        check({tag, "_stall_cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    initial begin
        ins_t i;
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_data_addr", data_addr, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // LB at 0x1003, accepted at issue, response next cycle
        i = blank(); i.memen = 1'b1; i.ld = LD_LB; i.alu = 32'h0000_1003; i.rd = 32'h80FF_1234;
        i.rw = 4'hF; i.wa = 5'd5; i.lit_en = 1'b1; i.lit = 32'hFFFF_FF80; i.lit_stall = 1;
        dq.push_back(i);
        // SW with acceptance delayed three cycles
        i = blank(); i.memen = 1'b1; i.mw = 4'hF; i.alu = 32'h0000_2000; i.wd = 32'h1234_5678;
        i.a_dly = 3; i.d_dly = 2; i.lit_stall = 5;
        dq.push_back(i);
        i = blank(); i.memen = 1'b1; i.ld = LD_LWL; i.alu = 32'h0000_3001; i.rt = 32'hAABB_CCDD;
        i.rd = 32'h1122_3344; i.rw = 4'hF; i.wa = 5'd6; i.lit_en = 1'b1; i.lit = 32'h3344_CCDD;
        dq.push_back(i);
        i = blank(); i.memen = 1'b1; i.ld = LD_LWR; i.alu = 32'h0000_3002; i.rt = 32'hAABB_CCDD;
        i.rd = 32'h1122_3344; i.rw = 4'hF; i.wa = 5'd7; i.lit_en = 1'b1; i.lit = 32'hAABB_1122;
        dq.push_back(i);
        i = blank(); i.mt = 2'b10; i.rs = 32'hDEAD_BEEF; i.alu = 32'h55;
        dq.push_back(i);
        i = blank(); i.mf = 2'b10; i.alu = 32'h77; i.rw = 4'hF; i.wa = 5'd8;
        i.lit_en = 1'b1; i.lit = 32'hDEAD_BEEF; i.lit_stall = 0;
        dq.push_back(i);
        // LW flushed while waiting for data, followed by a LW that must wait for the orphan
        i = blank(); i.memen = 1'b1; i.ld = LD_LW; i.alu = 32'h0000_4000; i.d_dly = 3; i.flush_at = 2;
        i.rw = 4'hF; i.wa = 5'd9;
        dq.push_back(i);
        i = blank(); i.memen = 1'b1; i.ld = LD_LW; i.alu = 32'h0000_5000; i.rd = 32'hCAFE_F00D;
        i.rw = 4'hF; i.wa = 5'd10; i.lit_en = 1'b1; i.lit = 32'hCAFE_F00D; i.lit_stall = 2;
        dq.push_back(i);

        for (int n = 0; n < 100 && (dq.size() != 0 || cur.valid || t_st != 0); n++) step();
        if (dq.size() != 0 || cur.valid || t_st != 0) check("directed_drain", 32'd1, 32'd0);

        // Reset while a request is waiting for acceptance
        i = blank(); i.memen = 1'b1; i.ld = LD_LW; i.alu = 32'h0000_6000; i.a_dly = 1000;
        i.rw = 4'hF; i.wa = 5'd11;
        dq.push_back(i);
        repeat (4) step();
        check("pre_reset_req_pending", 32'(t_st), 32'd1);
        chk_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        drive_idle();
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;

        i = blank(); i.mf = 2'b10; i.rw = 4'hF; i.wa = 5'd12; i.alu = 32'h99;
        i.lit_en = 1'b1; i.lit = 32'h0; i.lit_stall = 0;
        dq.push_back(i);
        i = blank(); i.mf = 2'b01; i.rw = 4'hF; i.wa = 5'd13; i.alu = 32'h98;
        i.lit_en = 1'b1; i.lit = 32'h0; i.lit_stall = 0;
        dq.push_back(i);

        rand_mode = 1'b1;
        for (int n = 0; n < 4000; n++) step();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
